// File: rtl/result_readin.sv
// result_readin: receiver/decoder for the 2-wire result link.
// Recovers 16-bit frames (4'b1101 header + 12-bit payload, MSB first)
// from the UserInput symbol pair and presents the payload with a strobe.
// Ports: clk, rst (sync, active-high), UserInput[1:0] (01=1, 10=0),
//        Result[11:0] (last good payload), Result_vld, Rx_err (strobes).
// Option: define RESULT_READIN_SYNC_EN to add a 2-flop input synchroniser.
module result_readin #(
    parameter int BIT_CYCLES = 25,
    parameter int HALF       = BIT_CYCLES / 2,
    parameter int MIN_RUN    = 2 * BIT_CYCLES - HALF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  UserInput,
    output logic [11:0] Result,
    output logic        Result_vld,
    output logic        Rx_err
);

    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0] HALF_P = PW'(HALF);
    localparam logic [PW-1:0] LAST_P = PW'(BIT_CYCLES - 1);
    localparam logic [7:0] MIN_RUN_P = 8'(MIN_RUN);
    localparam logic [1:0] SYM1 = 2'b01;
    localparam logic [1:0] SYM0 = 2'b10;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    logic [1:0]    sym;
    logic [1:0]    prev;
    logic [7:0]    run;
    logic [PW-1:0] phase;
    logic [3:0]    bitidx;
    logic [11:0]   shreg;
    state_t        state;

`ifdef RESULT_READIN_SYNC_EN
    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= SYM0;
            sync2 <= SYM0;
        end else begin
            sync1 <= UserInput;
            sync2 <= sync1;
        end
    end

    assign sym = sync2;
`else
    assign sym = UserInput;
`endif

    logic change;
    logic sym_ok;
    logic at_half;
    logic at_wrap;
    logic anchor;
    logic abort;

    assign change  = (sym != prev);
    assign sym_ok  = (sym == SYM1) || (sym == SYM0);
    assign at_half = (phase == HALF_P);
    assign at_wrap = (phase == LAST_P);
    // Header bit 13 is the only 0 in the header, so a long 01 run
    // ending in 10 marks the start of a frame.
    assign anchor  = change && (prev == SYM1) && (sym == SYM0)
                     && (run >= MIN_RUN_P);

    // A transition landing exactly on the sample point means the
    // bit boundary cannot be trusted, so it aborts like a bad symbol.
    always_comb begin
        abort = 1'b0;
        if (state != IDLE && at_half) begin
            if (change || !sym_ok) begin
                abort = 1'b1;
            end else if (state == HDR) begin
                if (bitidx == 4'd13) begin
                    abort = (sym != SYM0);
                end else begin
                    abort = (sym != SYM1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= SYM0;
            run        <= '0;
            phase      <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            Result     <= '0;
            Result_vld <= 1'b0;
            Rx_err     <= 1'b0;
        end else begin
            prev       <= sym;
            Result_vld <= 1'b0;
            Rx_err     <= 1'b0;

            if (change || (state == IDLE && !sym_ok)) begin
                run <= '0;
            end else if (run != 8'hFF) begin
                run <= run + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (anchor) begin
                        phase  <= '0;
                        bitidx <= 4'd13;
                        state  <= HDR;
                    end
                end
                HDR, DATA: begin
                    if (abort) begin
                        Rx_err <= 1'b1;
                        shreg  <= '0;
                        state  <= IDLE;
                    end else if (at_half) begin
                        phase <= phase + 1'b1;
                        if (state == HDR) begin
                            // bitidx advances to 11 at the next boundary
                            if (bitidx != 4'd13) begin
                                state <= DATA;
                            end
                        end else begin
                            shreg <= {shreg[10:0], sym == SYM1};
                            if (bitidx == 4'd0) begin
                                Result     <= {shreg[10:0], sym == SYM1};
                                Result_vld <= 1'b1;
                                state      <= IDLE;
                            end
                        end
                    end else if (change || at_wrap) begin
                        // Early edge (before the sample) only realigns;
                        // late edge or wrap also moves to the next bit.
                        phase <= '0;
                        if (at_wrap || phase > HALF_P) begin
                            bitidx <= bitidx - 4'd1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_readin.sv
// tb_result_readin: self-checking bench for result_readin.
// Drives frames on UserInput and scoreboards Result/Result_vld/Rx_err.
module tb_result_readin;

    localparam int BC = 25;
`ifdef RESULT_READIN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  UserInput = 2'b10;
    logic [11:0] Result;
    logic        Result_vld;
    logic        Rx_err;

    result_readin #(.BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .UserInput (UserInput),
        .Result    (Result),
        .Result_vld(Result_vld),
        .Rx_err    (Rx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [11:0] val;
        int          at;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total = 0;
    int err_cnt = 0;
    int last_err_cyc = -1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (Rx_err === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (Result_vld === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_vld: Result=%h at cycle %0d, none expected",
                         Result, cyc);
            end else begin
                e = sb.pop_front();
                if (Result !== e.val) begin
                    $display("FAIL result_value: got %h, want %h", Result, e.val);
                end else begin
                    passed++;
                end
                if (e.at >= 0) begin
                    total++;
                    if (cyc !== e.at) begin
                        $display("FAIL vld_timing: strobe at cycle %0d, want %0d",
                                 cyc, e.at);
                    end else begin
                        passed++;
                    end
                end
            end
        end
    end

    // Sends one frame; drift alternates 24/26-cycle bits, bad_bit forces
    // 11 for that whole bit, rst_bit pulses rst during that bit.
    task automatic send_frame(input logic [15:0] f, input bit drift,
                              input int bad_bit, input int rst_bit,
                              input bit push, output int t0);
        int per;
        logic [1:0] s;
        t0 = -1;
        for (int i = 15; i >= 0; i--) begin
            per = drift ? ((i % 2 == 1) ? 24 : 26) : BC;
            s = f[i] ? 2'b01 : 2'b10;
            if (i == bad_bit) s = 2'b11;
            UserInput = s;
            if (i == 13) begin
                t0 = cyc + 1 + LAT;
                if (push) sb.push_back('{f[11:0], drift ? -1 : t0 + 338});
            end
            if (i == rst_bit) begin
                repeat (5) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                total++;
                if (Result !== 12'h000) $display("FAIL rst_result: got %h, want 000", Result);
                else passed++;
                total++;
                if (Result_vld !== 1'b0) $display("FAIL rst_vld: got %b, want 0", Result_vld);
                else passed++;
                total++;
                if (Rx_err !== 1'b0) $display("FAIL rst_err: got %b, want 0", Rx_err);
                else passed++;
                repeat (per - 6) @(posedge clk);
                #1;
            end else begin
                repeat (per) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (Result !== 12'h000) $display("FAIL reset_result: got %h, want 000", Result);
        else passed++;
        total++;
        if (Result_vld !== 1'b0) $display("FAIL reset_vld: got %b, want 0", Result_vld);
        else passed++;
        total++;
        if (Rx_err !== 1'b0) $display("FAIL reset_err: got %b, want 0", Rx_err);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hD5A5, 1'b0, -1, -1, 1'b1, t0);
        total++;
        if (sb.size() != 0) $display("FAIL single_pending: %0d results missing, want 0", sb.size());
        else passed++;
        total++;
        if (err_cnt !== e0) $display("FAIL single_err: %0d errors, want %0d", err_cnt, e0);
        else passed++;
        total++;
        if (Result !== 12'h5A5) $display("FAIL single_hold: got %h, want 5a5", Result);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hDFFF, 1'b0, -1, -1, 1'b1, t0);
        total++;
        if (Result !== 12'hFFF) $display("FAIL b2b_first: got %h, want fff", Result);
        else passed++;
        send_frame(16'hD001, 1'b0, -1, -1, 1'b1, t0);
        total++;
        if (sb.size() != 0) $display("FAIL b2b_pending: %0d results missing, want 0", sb.size());
        else passed++;
        total++;
        if (err_cnt !== e0) $display("FAIL b2b_err: %0d errors, want %0d", err_cnt, e0);
        else passed++;
        total++;
        if (Result !== 12'h001) $display("FAIL b2b_second: got %h, want 001", Result);
        else passed++;
    endtask

    task automatic test_invalid_symbol();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hD555, 1'b0, 7, -1, 1'b0, t0);
        total++;
        if (err_cnt !== e0 + 1) $display("FAIL inv_err_count: %0d errors, want %0d", err_cnt, e0 + 1);
        else passed++;
        total++;
        if (last_err_cyc !== t0 + 163) $display("FAIL inv_err_time: cycle %0d, want %0d", last_err_cyc, t0 + 163);
        else passed++;
        total++;
        if (Result !== 12'h001) $display("FAIL inv_hold: got %h, want 001", Result);
        else passed++;
        send_frame(16'hD123, 1'b0, -1, -1, 1'b1, t0);
        total++;
        if (Result !== 12'h123) $display("FAIL inv_recover: got %h, want 123", Result);
        else passed++;
        total++;
        if (err_cnt !== e0 + 1) $display("FAIL inv_recover_err: %0d errors, want %0d", err_cnt, e0 + 1);
        else passed++;
    endtask

    task automatic test_bad_header();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hC000, 1'b0, -1, -1, 1'b0, t0);
        total++;
        if (err_cnt !== e0 + 1) $display("FAIL hdr_err_count: %0d errors, want %0d", err_cnt, e0 + 1);
        else passed++;
        total++;
        if (last_err_cyc !== t0 + 38) $display("FAIL hdr_err_time: cycle %0d, want %0d", last_err_cyc, t0 + 38);
        else passed++;
        total++;
        if (Result !== 12'h123) $display("FAIL hdr_hold: got %h, want 123", Result);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hD7FF, 1'b0, -1, 5, 1'b0, t0);
        total++;
        if (err_cnt !== e0) $display("FAIL midrst_err: %0d errors, want %0d", err_cnt, e0);
        else passed++;
        total++;
        if (Result !== 12'h000) $display("FAIL midrst_hold: got %h, want 000", Result);
        else passed++;
        send_frame(16'hDABC, 1'b0, -1, -1, 1'b1, t0);
        total++;
        if (Result !== 12'hABC) $display("FAIL midrst_next: got %h, want abc", Result);
        else passed++;
    endtask

    task automatic test_drift();
        int t0;
        int e0 = err_cnt;
        send_frame(16'hD3C3, 1'b1, -1, -1, 1'b1, t0);
        total++;
        if (sb.size() != 0) $display("FAIL drift_pending: %0d results missing, want 0", sb.size());
        else passed++;
        total++;
        if (err_cnt !== e0) $display("FAIL drift_err: %0d errors, want %0d", err_cnt, e0);
        else passed++;
        total++;
        if (Result !== 12'h3C3) $display("FAIL drift_value: got %h, want 3c3", Result);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid_symbol();
        test_bad_header();
        test_reset_midframe();
        test_drift();
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
